// File: rtl/spi_frame_arbiter.sv
// -----------------------------------------------------------------------------
// spi_frame_arbiter
//
// Shares one SPI byte engine between two requesters. A granted requester gets
// its own active-low chip select for a whole multi-byte frame. Its bytes are
// forwarded one at a time to the engine, and the bytes read back are returned
// to it. Grants alternate round-robin when both requesters contend.
//
// Parameters:
//   CS_SETUP  cycles from chip select falling to first o_tx_ready (min 1)
//   CS_HOLD   cycles from last byte complete to chip select rising (min 1)
//   TIMEOUT   idle-byte watchdog limit (only with SPI_FRAME_TIMEOUT_EN)
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req[1:0]              per-requester frame request, held for the frame
//   o_gnt[1:0]              one-hot grant
//   i_tx_valid/i_tx_last    requester byte offer / final-byte flag
//   i_tx_data0/i_tx_data1   bytes from requester 0 / 1
//   o_tx_ready[1:0]         byte accepted this cycle (granted requester only)
//   o_rx_valid, o_rx_data   one-cycle pulse with the byte just shifted in
//   o_abort                 one-cycle pulse on watchdog frame termination
//   o_cs_n[1:0]             active-low chip selects
//   o_spi_start/o_spi_data  start pulse and byte to the SPI engine
//   i_spi_busy, i_spi_new_data, i_spi_rx   status and read byte from engine
//
// Build option: define SPI_FRAME_TIMEOUT_EN to enable the watchdog that
// aborts a frame whose requester stalls in SEND for TIMEOUT cycles. Without
// it, o_abort is tied low and SEND waits indefinitely.
// -----------------------------------------------------------------------------
module spi_frame_arbiter #(
   parameter int CS_SETUP = 4,
   parameter int CS_HOLD  = 4,
   parameter int TIMEOUT  = 1024
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt,
   input  logic [1:0] i_tx_valid,
   input  logic [1:0] i_tx_last,
   input  logic [7:0] i_tx_data0,
   input  logic [7:0] i_tx_data1,
   output logic [1:0] o_tx_ready,
   output logic       o_rx_valid,
   output logic [7:0] o_rx_data,
   output logic       o_abort,
   output logic [1:0] o_cs_n,
   output logic       o_spi_start,
   output logic [7:0] o_spi_data,
   input  logic       i_spi_busy,
   input  logic       i_spi_new_data,
   input  logic [7:0] i_spi_rx
);
   localparam int SETUP_N = (CS_SETUP < 1) ? 1 : CS_SETUP;
   localparam int HOLD_N  = (CS_HOLD  < 1) ? 1 : CS_HOLD;
   localparam int CNT_MAX = (SETUP_N > HOLD_N) ? SETUP_N : HOLD_N;
   // The counter only ever reaches N-1, so clog2(N) bits are enough.
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SEND, S_START, S_WAIT, S_HOLD} state_t;

   state_t             r_state, w_state_next;
   logic               r_g;          // index of the granted requester
   logic               r_last_g;     // requester granted in the previous frame
   logic [1:0]         r_gnt;
   logic [1:0]         r_cs_n;
   logic [CNT_W-1:0]   r_cnt;
   logic [7:0]         r_spi_data;
   logic               r_last_flag;
   logic               r_nd_d;
   logic               r_rx_valid;
   logic [7:0]         r_rx_data;

   logic               w_grant, w_grant_idx, w_accept, w_release, w_cnt_clr;
   logic               w_rx_pulse, w_timeout_hit;

   // ---------------- next-state / control ----------------
   always_comb begin
      w_state_next = r_state;
      w_grant      = 1'b0;
      w_grant_idx  = 1'b0;
      w_accept     = 1'b0;
      w_release    = 1'b0;
      w_cnt_clr    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|i_req) begin
               w_grant      = 1'b1;
               // Both asking: the one not served last wins.
               w_grant_idx  = (i_req == 2'b11) ? ~r_last_g : i_req[1];
               w_cnt_clr    = 1'b1;
               w_state_next = S_SETUP;
            end
         end
         S_SETUP: begin
            if (r_cnt == CNT_W'(SETUP_N - 1)) w_state_next = S_SEND;
         end
         S_SEND: begin
            if (i_tx_valid[r_g]) begin
               w_accept     = 1'b1;
               w_state_next = S_START;
            end else if (!i_req[r_g] || w_timeout_hit) begin
               w_cnt_clr    = 1'b1;
               w_state_next = S_HOLD;
            end
         end
         S_START: w_state_next = S_WAIT;
         S_WAIT: begin
            if (!i_spi_busy) begin
               if (r_last_flag || !i_req[r_g]) begin
                  w_cnt_clr    = 1'b1;
                  w_state_next = S_HOLD;
               end else begin
                  w_state_next = S_SEND;
               end
            end
         end
         S_HOLD: begin
            if (r_cnt == CNT_W'(HOLD_N - 1)) begin
               w_release    = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // The engine keeps new_data high for a long time; only its rising edge
   // inside WAIT marks a fresh byte.
   assign w_rx_pulse = (r_state == S_WAIT) && i_spi_new_data && !r_nd_d;

   // ---------------- state and datapath registers ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_g         <= 1'b0;
         r_last_g    <= 1'b1;   // so requester 0 wins the first contention
         r_gnt       <= 2'b00;
         r_cs_n      <= 2'b11;
         r_cnt       <= '0;
         r_spi_data  <= 8'h00;
         r_last_flag <= 1'b0;
         r_nd_d      <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_rx_data   <= 8'h00;
      end else begin
         r_state    <= w_state_next;
         r_nd_d     <= i_spi_new_data;
         r_rx_valid <= w_rx_pulse;
         if (w_rx_pulse) r_rx_data <= i_spi_rx;

         if (w_cnt_clr)                                  r_cnt <= '0;
         else if (r_state == S_SETUP || r_state == S_HOLD) r_cnt <= r_cnt + 1'b1;

         if (w_grant) begin
            r_g    <= w_grant_idx;
            r_gnt  <= w_grant_idx ? 2'b10 : 2'b01;
            r_cs_n <= w_grant_idx ? 2'b01 : 2'b10;
         end else if (w_release) begin
            r_gnt    <= 2'b00;
            r_cs_n   <= 2'b11;
            r_last_g <= r_g;
         end

         if (w_accept) begin
            r_spi_data  <= r_g ? i_tx_data1 : i_tx_data0;
            r_last_flag <= i_tx_last[r_g];
         end
      end
   end

`ifdef SPI_FRAME_TIMEOUT_EN
   logic [15:0] r_to_cnt;
   logic        r_abort;

   assign w_timeout_hit = (r_to_cnt == 16'(TIMEOUT - 1));

   // Counts SEND cycles without an offered byte; any other state or an
   // accept restarts it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_to_cnt <= 16'd0;
         r_abort  <= 1'b0;
      end else begin
         if (r_state != S_SEND || w_accept) r_to_cnt <= 16'd0;
         else if (!w_timeout_hit)           r_to_cnt <= r_to_cnt + 16'd1;
         // A requester that already dropped req ends normally, not aborted.
         r_abort <= (r_state == S_SEND) && !i_tx_valid[r_g] && i_req[r_g] && w_timeout_hit;
      end
   end
   assign o_abort = r_abort;
`else
   assign w_timeout_hit = 1'b0;
   assign o_abort       = 1'b0;
   // TIMEOUT only sizes the watchdog, which is absent in this build.
   if (TIMEOUT != 0) begin : g_watchdog_absent
   end
`endif

   assign o_gnt       = r_gnt;
   assign o_cs_n      = r_cs_n;
   assign o_tx_ready  = (r_state == S_SEND) ? r_gnt : 2'b00;
   assign o_spi_start = (r_state == S_START);
   assign o_spi_data  = r_spi_data;
   assign o_rx_valid  = r_rx_valid;
   assign o_rx_data   = r_rx_data;

endmodule

// File: tb/tb_spi_frame_arbiter.sv
module tb_spi_frame_arbiter;
   localparam int CS_SETUP = 4;
   localparam int CS_HOLD  = 4;
   localparam int TIMEOUT  = 16;
   localparam int BUSY_LEN = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req = 2'b00;
   logic [1:0] tx_valid = 2'b00;
   logic [1:0] tx_last = 2'b00;
   logic [7:0] tx_data0 = 8'h00;
   logic [7:0] tx_data1 = 8'h00;
   logic       spi_busy = 1'b0;
   logic       spi_new_data = 1'b0;
   logic [7:0] spi_rx = 8'h00;
   logic [1:0] gnt, tx_ready, cs_n;
   logic       rx_valid, abort, spi_start;
   logic [7:0] rx_data, spi_data;

   int vectors = 0;
   int errors  = 0;

   // SPI engine model and event monitors
   int         busy_cnt = 0;
   int         nd_cnt = 0;
   int         model_nd_len = 2;
   logic [7:0] model_rx = 8'h5E;
   int         start_count = 0;
   int         rx_count = 0;
   int         abort_count = 0;
   logic [7:0] rx_last = 8'h00;

   spi_frame_arbiter #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .o_gnt(gnt),
      .i_tx_valid(tx_valid), .i_tx_last(tx_last),
      .i_tx_data0(tx_data0), .i_tx_data1(tx_data1), .o_tx_ready(tx_ready),
      .o_rx_valid(rx_valid), .o_rx_data(rx_data), .o_abort(abort), .o_cs_n(cs_n),
      .o_spi_start(spi_start), .o_spi_data(spi_data),
      .i_spi_busy(spi_busy), .i_spi_new_data(spi_new_data), .i_spi_rx(spi_rx)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst) begin
         spi_busy = 1'b0; spi_new_data = 1'b0; busy_cnt = 0; nd_cnt = 0;
      end else begin
         if (nd_cnt > 0) begin
            nd_cnt = nd_cnt - 1;
            if (nd_cnt == 0) spi_new_data = 1'b0;
         end
         if (spi_busy) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) begin
               spi_busy = 1'b0; spi_new_data = 1'b1; spi_rx = model_rx; nd_cnt = model_nd_len;
            end
         end else if (spi_start) begin
            spi_busy = 1'b1; busy_cnt = BUSY_LEN; spi_new_data = 1'b0; nd_cnt = 0;
         end
         if (spi_start) start_count = start_count + 1;
         if (rx_valid) begin rx_count = rx_count + 1; rx_last = rx_data; end
         if (abort) abort_count = abort_count + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte once tx_ready appears; returns in the START cycle.
   task automatic send_byte(input int idx, input logic [7:0] d, input logic last);
      int n;
      n = 0;
      while (tx_ready[idx] !== 1'b1 && n < 200) begin tick(); n++; end
      vectors++;
      if (tx_ready[idx] !== 1'b1) begin
         errors++; $display("FAIL tx_ready_wait[%0d]: tx_ready=%b, required bit %0d high within 200 cycles", idx, tx_ready, idx);
      end
      tx_valid[idx] = 1'b1; tx_last[idx] = last;
      if (idx == 0) tx_data0 = d; else tx_data1 = d;
      tick();
      tx_valid = 2'b00; tx_last = 2'b00;
      vectors++;
      if (spi_start !== 1'b1 || spi_data !== d) begin
         errors++; $display("FAIL start_byte: spi_start=%b spi_data=%h, required 1 and %h", spi_start, spi_data, d);
      end
      $display("byte req%0d data=%h last=%b spi_start=%b spi_data=%h", idx, d, last, spi_start, spi_data);
   endtask

   // From the START cycle, advance to the first cycle where busy is seen low.
   task automatic wait_busy_fall();
      int n;
      n = 0;
      tick();
      while (spi_busy && n < 200) begin tick(); n++; end
      vectors++;
      if (spi_busy !== 1'b0) begin
         errors++; $display("FAIL busy_fall: spi_busy=%b, required 0 within 200 cycles", spi_busy);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (gnt !== 2'b00 && n < 200) begin tick(); n++; end
      vectors++;
      if (gnt !== 2'b00 || cs_n !== 2'b11) begin
         errors++; $display("FAIL frame_end: gnt=%b cs_n=%b, required 00 and 11", gnt, cs_n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      vectors++;
      if (gnt !== 2'b00 || cs_n !== 2'b11 || tx_ready !== 2'b00) begin
         errors++; $display("FAIL reset_ctl: gnt=%b cs_n=%b tx_ready=%b, required 00 11 00", gnt, cs_n, tx_ready);
      end
      vectors++;
      if (spi_start !== 1'b0 || spi_data !== 8'h00) begin
         errors++; $display("FAIL reset_spi: spi_start=%b spi_data=%h, required 0 00", spi_start, spi_data);
      end
      vectors++;
      if (rx_valid !== 1'b0 || rx_data !== 8'h00 || abort !== 1'b0) begin
         errors++; $display("FAIL reset_rx: rx_valid=%b rx_data=%h abort=%b, required 0 00 0", rx_valid, rx_data, abort);
      end
      rst = 1'b0;
      tick();
      $display("reset gnt=%b cs_n=%b", gnt, cs_n);
   endtask

   task automatic test_single_write();
      int s0;
      s0 = start_count;
      req = 2'b01;
      tick();
      vectors++;
      if (gnt !== 2'b01 || cs_n !== 2'b10) begin
         errors++; $display("FAIL grant_latency: gnt=%b cs_n=%b, required 01 10", gnt, cs_n);
      end
      repeat (CS_SETUP - 1) tick();
      vectors++;
      if (tx_ready !== 2'b00) begin
         errors++; $display("FAIL setup_early: tx_ready=%b, required 00", tx_ready);
      end
      tick();
      vectors++;
      if (tx_ready !== 2'b01) begin
         errors++; $display("FAIL setup_done: tx_ready=%b, required 01", tx_ready);
      end
      send_byte(0, 8'h0C, 1'b0);
      wait_busy_fall();
      vectors++;
      if (cs_n !== 2'b10 || tx_ready !== 2'b01) begin
         errors++; $display("FAIL between_bytes: cs_n=%b tx_ready=%b, required 10 01", cs_n, tx_ready);
      end
      send_byte(0, 8'h01, 1'b1);
      wait_busy_fall();
      req = 2'b00;
      repeat (CS_HOLD - 1) tick();
      vectors++;
      if (cs_n !== 2'b10) begin
         errors++; $display("FAIL hold_low: cs_n=%b, required 10", cs_n);
      end
      tick();
      vectors++;
      if (cs_n !== 2'b11 || gnt !== 2'b00) begin
         errors++; $display("FAIL hold_rise: cs_n=%b gnt=%b, required 11 00", cs_n, gnt);
      end
      vectors++;
      if (start_count - s0 !== 2) begin
         errors++; $display("FAIL start_count: got %0d start pulses, required 2", start_count - s0);
      end
      $display("single_write starts=%0d cs_n=%b", start_count - s0, cs_n);
   endtask

   task automatic test_readback();
      int r0;
      r0 = rx_count;
      model_nd_len = 64; model_rx = 8'hA5;
      req = 2'b10;
      send_byte(1, 8'h3C, 1'b1);
      wait_busy_fall();
      req = 2'b00;
      wait_idle();
      repeat (70) tick();
      vectors++;
      if (rx_count - r0 !== 1 || rx_last !== 8'hA5) begin
         errors++; $display("FAIL readback: %0d pulses data=%h, required 1 pulse data a5", rx_count - r0, rx_last);
      end
      model_nd_len = 2; model_rx = 8'h5E;
      $display("readback pulses=%0d data=%h", rx_count - r0, rx_last);
   endtask

   task automatic test_contention();
      logic [1:0] exp_gnt [4];
      int gap, n;
      exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
      rst = 1'b1; req = 2'b11;
      tick(); tick();
      rst = 1'b0;
      for (int f = 0; f < 4; f++) begin
         gap = 0; n = 0;
         while (gnt === 2'b00 && n < 50) begin
            if (cs_n !== 2'b11) gap = -100;
            gap++; tick(); n++;
         end
         vectors++;
         if (gnt !== exp_gnt[f] || cs_n !== ~exp_gnt[f]) begin
            errors++; $display("FAIL contention_grant[%0d]: gnt=%b cs_n=%b, required gnt %b", f, gnt, cs_n, exp_gnt[f]);
         end
         vectors++;
         if (gap < 1) begin
            errors++; $display("FAIL frame_gap[%0d]: gap=%0d, required >=1 cycle with cs_n=11", f, gap);
         end
         send_byte(exp_gnt[f][1] ? 1 : 0, 8'h40 + 8'(f), 1'b1);
         if (f == 3) req = 2'b00;
         wait_busy_fall();
         wait_idle();
         $display("contention frame %0d gnt=%b gap=%0d", f, exp_gnt[f], gap);
      end
      repeat (3) tick();
      vectors++;
      if (gnt !== 2'b00) begin
         errors++; $display("FAIL contention_done: gnt=%b, required 00", gnt);
      end
   endtask

   task automatic test_early_release();
      int r0, s0, a0, bad;
      r0 = rx_count; s0 = start_count; a0 = abort_count; bad = 0;
      req = 2'b10;
      send_byte(1, 8'h11, 1'b0);
      wait_busy_fall();
      send_byte(1, 8'h22, 1'b0);
      tick();
      req = 2'b00;
      wait_busy_fall();
      for (int i = 0; i < CS_HOLD; i++) begin
         if (cs_n !== 2'b01 || tx_ready !== 2'b00) bad++;
         tick();
      end
      vectors++;
      if (bad != 0) begin
         errors++; $display("FAIL early_hold: %0d bad hold cycles, required cs_n=01 tx_ready=00 throughout", bad);
      end
      vectors++;
      if (cs_n !== 2'b11 || gnt !== 2'b00) begin
         errors++; $display("FAIL early_rise: cs_n=%b gnt=%b, required 11 00", cs_n, gnt);
      end
      repeat (4) tick();
      vectors++;
      if (start_count - s0 !== 2 || rx_count - r0 !== 2 || abort_count != a0) begin
         errors++; $display("FAIL early_counts: starts=%0d rx=%0d aborts=%0d, required 2 2 0",
                            start_count - s0, rx_count - r0, abort_count - a0);
      end
      $display("early_release starts=%0d rx=%0d", start_count - s0, rx_count - r0);
   endtask

   task automatic test_reset_mid_frame();
      req = 2'b10;
      send_byte(1, 8'h5A, 1'b0);
      tick();
      rst = 1'b1;
      #1;
      vectors++;
      if (cs_n !== 2'b11 || gnt !== 2'b00 || spi_start !== 1'b0 || spi_data !== 8'h00) begin
         errors++; $display("FAIL async_reset: cs_n=%b gnt=%b spi_start=%b spi_data=%h, required 11 00 0 00",
                            cs_n, gnt, spi_start, spi_data);
      end
      req = 2'b00;
      tick(); tick();
      rst = 1'b0;
      req = 2'b10;
      tick();
      vectors++;
      if (gnt !== 2'b10 || cs_n !== 2'b01) begin
         errors++; $display("FAIL regrant: gnt=%b cs_n=%b, required 10 01", gnt, cs_n);
      end
      send_byte(1, 8'h6B, 1'b1);
      wait_busy_fall();
      req = 2'b00;
      wait_idle();
      $display("reset_mid_frame regrant ok cs_n=%b", cs_n);
   endtask

   task automatic test_send_wait();
      int n, a0;
      a0 = abort_count; n = 0;
      req = 2'b01;
      while (tx_ready !== 2'b01 && n < 50) begin tick(); n++; end
`ifdef SPI_FRAME_TIMEOUT_EN
      repeat (TIMEOUT - 1) tick();
      vectors++;
      if (abort !== 1'b0 || tx_ready !== 2'b01) begin
         errors++; $display("FAIL abort_early: abort=%b tx_ready=%b, required 0 01", abort, tx_ready);
      end
      tick();
      req = 2'b00;
      vectors++;
      if (abort !== 1'b1 || tx_ready !== 2'b00) begin
         errors++; $display("FAIL abort_pulse: abort=%b tx_ready=%b, required 1 00", abort, tx_ready);
      end
      tick();
      vectors++;
      if (abort !== 1'b0) begin
         errors++; $display("FAIL abort_width: abort=%b, required 0", abort);
      end
      wait_idle();
`else
      repeat (40) tick();
      vectors++;
      if (tx_ready !== 2'b01 || abort_count != a0) begin
         errors++; $display("FAIL send_waits: tx_ready=%b aborts=%0d, required 01 0", tx_ready, abort_count - a0);
      end
      req = 2'b00;
      tick();
      vectors++;
      if (tx_ready !== 2'b00) begin
         errors++; $display("FAIL send_release: tx_ready=%b, required 00", tx_ready);
      end
      repeat (CS_HOLD - 1) tick();
      vectors++;
      if (cs_n !== 2'b10) begin
         errors++; $display("FAIL send_hold: cs_n=%b, required 10", cs_n);
      end
      tick();
      vectors++;
      if (cs_n !== 2'b11 || abort_count != a0) begin
         errors++; $display("FAIL send_end: cs_n=%b aborts=%0d, required 11 0", cs_n, abort_count - a0);
      end
`endif
      $display("send_wait aborts=%0d cs_n=%b", abort_count - a0, cs_n);
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_readback();
      test_contention();
      test_early_release();
      test_reset_mid_frame();
      test_send_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/spi_frame_arbiter.md
# spi_frame_arbiter

Shares one `spi` byte engine between two requesters (e.g. the max7219 display driver and a second SPI peripheral). It frames multi-byte transactions with a per-requester active-low chip select and grants requesters round-robin. Bytes are streamed through it one at a time, and the read bytes are returned to the granted requester. It sits between the requester FSMs and the `spi` instance's `start`/`data_in`/`busy`/`new_data`/`data_out` pins.

## Interface
- `CS_SETUP`, 4: cycles from chip select falling to first `tx_ready`; minimum 1.
- `CS_HOLD`, 4: cycles from last byte complete to chip select rising; minimum 1.
- `TIMEOUT`, 1024: idle-byte watchdog limit, used only with the config macro.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  2  per-requester frame request, held high for the whole frame.
- `gnt`  out  2  one-hot grant.
- `tx_valid`  in  2  requester has a byte.
- `tx_last`  in  2  byte offered is the frame's final byte.
- `tx_data0`, `tx_data1`  in  8 each  byte from requester 0 / 1.
- `tx_ready`  out  2  arbiter accepts the byte this cycle.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` holds the byte just shifted in.
- `rx_data`  out  8  received byte, for the granted requester.
- `abort`  out  1  one-cycle pulse when a frame is force-terminated.
- `cs_n`  out  2  chip selects, active low.
- `spi_start`  out  1  start pulse to `spi`.
- `spi_data`  out  8  to `spi` `data_in`.
- `spi_busy`  in  1  `spi` busy.
- `spi_new_data`  in  1  `spi` new_data.
- `spi_rx`  in  8  `spi` data_out.

## Operation
- **Reset values:** `gnt`=0, `cs_n`=2'b11, `spi_start`=0, `spi_data`=0, `rx_valid`=0, `rx_data`=0, `abort`=0, `tx_ready`=0. The round-robin pointer favours requester 0.
- **FSM:** IDLE, SETUP, SEND, START, WAIT, HOLD.
- **IDLE:**
  - If any `req` is high, grant one requester. With both high, grant the one not granted last.
  - Set `gnt[g]`=1 and `cs_n[g]`=0, clear the counter, go to SETUP.
- **SETUP:** count `CS_SETUP` cycles, then go to SEND.
- **SEND:**
  - `tx_ready[g]`=1 (combinational from state and `gnt`); the other requester's `tx_ready` is 0.
  - On `tx_valid[g]`: latch `tx_data<g>` into `spi_data`, latch `tx_last[g]`, go to START.
  - If `req[g]` is low: go to HOLD (early end, no `abort`).
- **START:** `spi_start`=1 for exactly this cycle; go to WAIT.
- **WAIT:**
  - On the rising edge of `spi_new_data`, pulse `rx_valid` with `rx_data`=`spi_rx`. `spi` holds `new_data` high for many cycles, so exactly one pulse per byte is required.
  - When `spi_busy`=0, go to HOLD if the latched last flag is set or `req[g]` is low; otherwise go to SEND.
- **HOLD:** count `CS_HOLD` cycles. Then set `cs_n`=2'b11 and `gnt`=0, record `g` as last-granted, go to IDLE.
- **Request timing:** `req` dropping mid-byte never truncates the byte in flight. `req` is sampled only in IDLE, SEND and WAIT.
- **Grant stability:** the grant never changes inside a frame. A requester re-asserting `req` in IDLE while the other is waiting loses to the other.
- **Reset mid-frame:** `cs_n` deasserts immediately (asynchronous). The `spi` reset is owned elsewhere.

## Timing
- `req` rises at cycle 0 in IDLE:
  - `gnt`/`cs_n` change at cycle 1.
  - `tx_ready` is high from cycle 1+`CS_SETUP`.
- Byte accepted at cycle t: `spi_start` is high at t+1, WAIT starts at t+2.
- `spi_busy` is evaluated from the first WAIT cycle. `spi_data` is stable from t+1 until the next accept.
- Back-to-back bytes: a new accept is possible the cycle after `spi_busy` is seen low.
- Minimum frame gap: `cs_n` is high for at least 1 cycle (IDLE) between frames, even for the same requester.

## Configuration
- **`SPI_FRAME_TIMEOUT_EN` defined:**
  - A 16-bit counter runs in SEND while `tx_valid[g]`=0 and clears on accept.
  - On reaching `TIMEOUT`: pulse `abort` for 1 cycle, go to HOLD.
- **Not defined:** no counter; `abort` is tied 0; SEND waits indefinitely.

## Test plan
- **Single write:** `req[0]`=1, bytes 0x0C, 0x01 with `tx_last` on the second.
  - `cs_n[0]` low for the whole frame.
  - Two `spi_start` pulses, `spi_data` 0x0C then 0x01.
  - `cs_n[0]` rises `CS_HOLD` cycles after the final busy fall.
- **Contention:** `req`=2'b11 from reset.
  - Requester 0 is served first, then requester 1.
  - With both held, grants alternate 0,1,0,1 over four frames, each separated by ≥1 cycle of `cs_n`=2'b11.
- **Readback:** model `spi` returns 0xA5 with `new_data` high for 64 cycles.
  - Exactly one `rx_valid` pulse, `rx_data`=0xA5.
- **Early release:** drop `req[1]` during the second byte's WAIT.
  - Byte completes, no further `tx_ready`, `cs_n[1]` rises after `CS_HOLD`, `abort`=0.
- **Reset mid-frame:** assert `rst` during WAIT.
  - `cs_n`=2'b11, `gnt`=0, `spi_start`=0 immediately.
  - After release, a new `req[1]` is granted normally.
- **`SPI_FRAME_TIMEOUT_EN` only:** `TIMEOUT`=16, grant requester 0 with `tx_valid` held low.
  - `abort` pulses 16 cycles into SEND, then HOLD, then IDLE.
